// File: rtl/slack_horizon_sched_pkg.sv
// mpc_pkg: shared fixed-point type, dimension defaults and scheduler states
// for the ADMM slack-step horizon sequencer.
package mpc_pkg;

  localparam int DEF_W           = 16;
  localparam int DEF_STATE_DIM   = 12;
  localparam int DEF_CONTROL_DIM = 4;

  typedef logic signed [DEF_W-1:0] fixed_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/slack_horizon_sched_if.sv
// Bundle of control, trajectory read, engine and write-back signals
// between the slack scheduler (master) and its environment (slave).
interface slack_horizon_sched_if #(
  parameter int STATE_DIM   = mpc_pkg::DEF_STATE_DIM,
  parameter int CONTROL_DIM = mpc_pkg::DEF_CONTROL_DIM,
  parameter int W           = mpc_pkg::DEF_W,
  parameter int AW          = 4
);

  logic                             start;
  logic                             abort;
  logic [W-1:0]                     cfg_x_min;
  logic [W-1:0]                     cfg_x_max;
  logic [W-1:0]                     cfg_u_min;
  logic [W-1:0]                     cfg_u_max;
  logic                             busy;
  logic                             done;

  logic                             rd_en;
  logic [AW-1:0]                    rd_addr;
  logic [STATE_DIM-1:0][W-1:0]      rd_x;
  logic [STATE_DIM-1:0][W-1:0]      rd_y;
  logic [CONTROL_DIM-1:0][W-1:0]    rd_u;
  logic [CONTROL_DIM-1:0][W-1:0]    rd_g;

  logic                             su_start;
  logic [STATE_DIM-1:0][W-1:0]      su_x;
  logic [STATE_DIM-1:0][W-1:0]      su_y;
  logic [CONTROL_DIM-1:0][W-1:0]    su_u;
  logic [CONTROL_DIM-1:0][W-1:0]    su_g;
  logic [W-1:0]                     su_x_min;
  logic [W-1:0]                     su_x_max;
  logic [W-1:0]                     su_u_min;
  logic [W-1:0]                     su_u_max;
  logic [STATE_DIM-1:0][W-1:0]      su_v;
  logic [CONTROL_DIM-1:0][W-1:0]    su_z;
  logic                             su_done;

  logic                             wr_en;
  logic                             wr_z_en;
  logic [AW-1:0]                    wr_addr;
  logic [STATE_DIM-1:0][W-1:0]      wr_v;
  logic [CONTROL_DIM-1:0][W-1:0]    wr_z;
  logic [W-1:0]                     max_resid;

  modport master (
    input  start, abort,
    input  cfg_x_min, cfg_x_max, cfg_u_min, cfg_u_max,
    output busy, done,
    output rd_en, rd_addr,
    input  rd_x, rd_y, rd_u, rd_g,
    output su_start, su_x, su_y, su_u, su_g,
    output su_x_min, su_x_max, su_u_min, su_u_max,
    input  su_v, su_z, su_done,
    output wr_en, wr_z_en, wr_addr, wr_v, wr_z,
    output max_resid
  );

  modport slave (
    output start, abort,
    output cfg_x_min, cfg_x_max, cfg_u_min, cfg_u_max,
    input  busy, done,
    input  rd_en, rd_addr,
    output rd_x, rd_y, rd_u, rd_g,
    input  su_start, su_x, su_y, su_u, su_g,
    input  su_x_min, su_x_max, su_u_min, su_u_max,
    output su_v, su_z, su_done,
    input  wr_en, wr_z_en, wr_addr, wr_v, wr_z,
    input  max_resid
  );

endinterface

// File: rtl/slack_horizon_sched_abs_diff_max.sv
// abs_diff_max: combinational max over i of |a_i - b_i|, differences in
// W+1 bits, magnitude saturated to the largest positive W-bit value.
module abs_diff_max #(
  parameter int N = 12,
  parameter int W = 16
) (
  input  logic [N-1:0][W-1:0] a,
  input  logic [N-1:0][W-1:0] b,
  output logic [W-1:0]        max_abs
);

  import mpc_pkg::*;

  localparam logic [W:0] SAT = {2'b00, {(W-1){1'b1}}};

  // reduce the saturated per-element magnitudes to their maximum
  always_comb begin
    logic [W:0]   diff;
    logic [W:0]   mag;
    logic [W-1:0] sat;
    max_abs = '0;
    diff    = '0;
    mag     = '0;
    sat     = '0;
    for (int i = 0; i < N; i++) begin
      diff = {a[i][W-1], a[i]} - {b[i][W-1], b[i]};
      mag  = diff[W] ? (~diff + 1'b1) : diff;
      sat  = (mag > SAT) ? SAT[W-1:0] : mag[W-1:0];
      if (sat > max_abs) max_abs = sat;
    end
  end

endmodule

// File: rtl/slack_horizon_sched.sv
// Horizon sequencer for one slack_update engine: read, fire, wait, write
// per knot. Define SLACK_SCHED_RESID_EN to build the max_resid tracker.
module slack_horizon_sched #(
  parameter int STATE_DIM   = mpc_pkg::DEF_STATE_DIM,
  parameter int CONTROL_DIM = mpc_pkg::DEF_CONTROL_DIM,
  parameter int W           = mpc_pkg::DEF_W,
  parameter int HORIZON     = 10,
  parameter int AW          = $clog2(HORIZON)
) (
  input  logic clk,
  input  logic reset,
  slack_horizon_sched_if.master bus
);

  import mpc_pkg::*;

  sched_state_e state;
  sched_state_e state_nx;

  logic [AW-1:0] k;
  logic          last;
  logic          accept;
  logic          rd_en_c;
  logic          su_start_c;
  logic          wr_en_c;
  logic          done_c;

  logic [STATE_DIM-1:0][W-1:0]   su_x_q;
  logic [STATE_DIM-1:0][W-1:0]   su_y_q;
  logic [CONTROL_DIM-1:0][W-1:0] su_u_q;
  logic [CONTROL_DIM-1:0][W-1:0] su_g_q;
  logic [STATE_DIM-1:0][W-1:0]   wr_v_q;
  logic [CONTROL_DIM-1:0][W-1:0] wr_z_q;
  logic [W-1:0] x_min_q;
  logic [W-1:0] x_max_q;
  logic [W-1:0] u_min_q;
  logic [W-1:0] u_max_q;

  assign last   = (k == AW'(HORIZON - 1));
  assign accept = (state == S_IDLE) && bus.start && !bus.abort;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next state and Moore strobes; abort kills strobes the same cycle
  always_comb begin
    state_nx   = state;
    rd_en_c    = 1'b0;
    su_start_c = 1'b0;
    wr_en_c    = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      S_IDLE:  if (bus.start) state_nx = S_READ;
      S_READ:  begin
        rd_en_c  = 1'b1;
        state_nx = S_LOAD;
      end
      S_LOAD:  state_nx = S_FIRE;
      S_FIRE:  begin
        su_start_c = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT:  if (bus.su_done) state_nx = S_WRITE;
      S_WRITE: begin
        wr_en_c  = 1'b1;
        state_nx = last ? S_DONE : S_READ;
      end
      S_DONE:  begin
        done_c   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (bus.abort) begin
      state_nx   = S_IDLE;
      rd_en_c    = 1'b0;
      su_start_c = 1'b0;
      wr_en_c    = 1'b0;
      done_c     = 1'b0;
    end
  end

  // knot index, bounds, operands and captured results
  always_ff @(posedge clk) begin
    if (reset) begin
      k       <= '0;
      x_min_q <= '0;
      x_max_q <= '0;
      u_min_q <= '0;
      u_max_q <= '0;
      su_x_q  <= '0;
      su_y_q  <= '0;
      su_u_q  <= '0;
      su_g_q  <= '0;
      wr_v_q  <= '0;
      wr_z_q  <= '0;
    end else if (accept) begin
      k       <= '0;
      x_min_q <= bus.cfg_x_min;
      x_max_q <= bus.cfg_x_max;
      u_min_q <= bus.cfg_u_min;
      u_max_q <= bus.cfg_u_max;
    end else if (!bus.abort) begin
      if (state == S_LOAD) begin
        su_x_q <= bus.rd_x;
        su_y_q <= bus.rd_y;
        su_u_q <= bus.rd_u;
        su_g_q <= bus.rd_g;
      end
      if (state == S_WAIT && bus.su_done) begin
        wr_v_q <= bus.su_v;
        wr_z_q <= bus.su_z;
      end
      if (state == S_WRITE && !last) k <= k + AW'(1);
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_c;
  assign bus.rd_en    = rd_en_c;
  assign bus.rd_addr  = k;
  assign bus.su_start = su_start_c;
  assign bus.su_x     = su_x_q;
  assign bus.su_y     = su_y_q;
  assign bus.su_u     = su_u_q;
  assign bus.su_g     = su_g_q;
  assign bus.su_x_min = x_min_q;
  assign bus.su_x_max = x_max_q;
  assign bus.su_u_min = u_min_q;
  assign bus.su_u_max = u_max_q;
  assign bus.wr_en    = wr_en_c;
  assign bus.wr_z_en  = wr_en_c && !last;
  assign bus.wr_addr  = k;
  assign bus.wr_v     = wr_v_q;
  assign bus.wr_z     = wr_z_q;

`ifdef SLACK_SCHED_RESID_EN
  logic [W-1:0] knot_resid;
  logic [W-1:0] resid_q;

  abs_diff_max #(
    .N (STATE_DIM),
    .W (W)
  ) u_resid (
    .a       (wr_v_q),
    .b       (su_x_q),
    .max_abs (knot_resid)
  );

  // running max of |v - x| across the sweep, cleared on start
  always_ff @(posedge clk) begin
    if (reset)                           resid_q <= '0;
    else if (accept)                     resid_q <= '0;
    else if (wr_en_c && knot_resid > resid_q) resid_q <= knot_resid;
  end

  assign bus.max_resid = resid_q;
`else
  assign bus.max_resid = '0;
`endif

endmodule

// File: tb/tb_slack_horizon_sched.sv
// Scoreboard bench for slack_horizon_sched: HORIZON=4, engine latency 3,
// memory and engine models; write-backs checked against a queue.
module tb_slack_horizon_sched;

  localparam int SD = 12;
  localparam int CD = 4;
  localparam int W  = 16;
  localparam int H  = 4;
  localparam int AW = $clog2(H);
  localparam int L  = 3;

  typedef logic [SD-1:0][W-1:0] svec_t;
  typedef logic [CD-1:0][W-1:0] cvec_t;
  typedef struct {
    int    k;
    svec_t v;
    cvec_t z;
    bit    zen;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slack_horizon_sched_if #(
    .STATE_DIM(SD), .CONTROL_DIM(CD), .W(W), .AW(AW)
  ) bus ();

  slack_horizon_sched #(
    .STATE_DIM(SD), .CONTROL_DIM(CD), .W(W), .HORIZON(H), .AW(AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  svec_t mem_x [H];
  svec_t mem_y [H];
  cvec_t mem_u [H];
  cvec_t mem_g [H];
  int cx_lo, cx_hi, cu_lo, cu_hi;

  function automatic int clampi(int s, int lo, int hi);
    if (s < lo) return lo;
    if (s > hi) return hi;
    return s;
  endfunction

  // trajectory memory: data one cycle after rd_en
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_x <= mem_x[bus.rd_addr];
      bus.rd_y <= mem_y[bus.rd_addr];
      bus.rd_u <= mem_u[bus.rd_addr];
      bus.rd_g <= mem_g[bus.rd_addr];
    end
  end

  // behavioural slack_update engine, latency L
  int    cnt = 0;
  logic  eng_done = 1'b0;
  logic  inj = 1'b0;
  svec_t ev;
  cvec_t ez;
  assign bus.su_done = eng_done | inj;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (reset) begin
      cnt <= 0;
    end else if (bus.su_start) begin
      cnt <= L - 1;
      for (int i = 0; i < SD; i++)
        ev[i] <= W'(clampi(int'($signed(bus.su_x[i])) + int'($signed(bus.su_y[i])),
                           int'($signed(bus.su_x_min)), int'($signed(bus.su_x_max))));
      for (int i = 0; i < CD; i++)
        ez[i] <= W'(clampi(int'($signed(bus.su_u[i])) + int'($signed(bus.su_g[i])),
                           int'($signed(bus.su_u_min)), int'($signed(bus.su_u_max))));
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        eng_done <= 1'b1;
        bus.su_v <= ev;
        bus.su_z <= ez;
      end
    end
  end

  // scoreboard: every write-back must match the next expected knot
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0d", bus.wr_addr);
      end else begin
        e = q.pop_front();
        checks++;
        if (bus.wr_addr !== AW'(e.k)) begin
          errors++;
          $display("FAIL wr_addr got %0d exp %0d", bus.wr_addr, e.k);
        end
        checks++;
        if (bus.wr_v !== e.v) begin
          errors++;
          $display("FAIL wr_v k=%0d got %h exp %h", e.k, bus.wr_v, e.v);
        end
        checks++;
        if (bus.wr_z !== e.z) begin
          errors++;
          $display("FAIL wr_z k=%0d got %h exp %h", e.k, bus.wr_z, e.z);
        end
        checks++;
        if (bus.wr_z_en !== e.zen) begin
          errors++;
          $display("FAIL wr_z_en k=%0d got %b exp %b", e.k, bus.wr_z_en, e.zen);
        end
      end
    end
  end

  function automatic void push_exp(int k);
    exp_t e;
    e.k = k;
    for (int i = 0; i < SD; i++)
      e.v[i] = W'(clampi(int'($signed(mem_x[k][i])) + int'($signed(mem_y[k][i])), cx_lo, cx_hi));
    for (int i = 0; i < CD; i++)
      e.z[i] = W'(clampi(int'($signed(mem_u[k][i])) + int'($signed(mem_g[k][i])), cu_lo, cu_hi));
    e.zen = (k < H - 1);
    q.push_back(e);
  endfunction

  task automatic set_cfg(int xl, int xh, int ul, int uh);
    cx_lo = xl; cx_hi = xh; cu_lo = ul; cu_hi = uh;
    bus.cfg_x_min = W'(xl);
    bus.cfg_x_max = W'(xh);
    bus.cfg_u_min = W'(ul);
    bus.cfg_u_max = W'(uh);
  endtask

  task automatic fill(int xs, int ys, int us, int gs, bit ramp);
    for (int k = 0; k < H; k++) begin
      for (int i = 0; i < SD; i++) begin
        mem_x[k][i] = ramp ? W'(i + 1)  : W'(xs);
        mem_y[k][i] = ramp ? W'(12 - i) : W'(ys);
      end
      for (int i = 0; i < CD; i++) begin
        mem_u[k][i] = ramp ? W'(i + 1) : W'(us);
        mem_g[k][i] = ramp ? W'(4 - i) : W'(gs);
      end
    end
  endtask

  // start a sweep; cyc = cycle of done counting the READ cycle as 1
  task automatic do_sweep(output int cyc);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = -1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (bus.done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.rd_en, bus.su_start, bus.wr_en, bus.wr_z_en} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 000000",
               {bus.busy, bus.done, bus.rd_en, bus.su_start, bus.wr_en, bus.wr_z_en});
    end
    checks++;
    if ({bus.rd_addr, bus.wr_addr} !== '0) begin
      errors++;
      $display("FAIL reset_addr got %0d/%0d exp 0/0", bus.rd_addr, bus.wr_addr);
    end
    checks++;
    if ((|bus.su_x) || (|bus.su_y) || (|bus.su_u) || (|bus.su_g) || (|bus.su_x_min)
        || (|bus.su_x_max) || (|bus.su_u_min) || (|bus.su_u_max)
        || $isunknown({bus.su_x, bus.su_x_min})) begin
      errors++;
      $display("FAIL reset_operands got nonzero exp 0");
    end
    checks++;
    if ({bus.wr_v, bus.wr_z, bus.max_resid} !== '0) begin
      errors++;
      $display("FAIL reset_wrdata got %h exp 0", {bus.wr_z, bus.max_resid});
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid;
    set_cfg(10, 12, 5, 6);
    fill(0, 0, 0, 0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.su_x_min !== '0 || bus.su_x !== '0) begin
      errors++;
      $display("FAIL reset_mid busy=%b xmin=%0d exp 0/0", bus.busy, bus.su_x_min);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_nominal;
    int cyc;
    set_cfg(10, 12, 5, 6);
    fill(0, 0, 0, 0, 1'b1);
    for (int k = 0; k < H; k++) push_exp(k);
    do_sweep(cyc);
    checks++;
    if (cyc != H * (4 + L) + 1) begin
      errors++;
      $display("FAIL nominal_done_cycle got %0d exp %0d", cyc, H * (4 + L) + 1);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL nominal_pending got %0d exp 0", q.size());
    end
    checks++;
    if (bus.su_x_min !== 16'd10 || bus.su_x_max !== 16'd12 ||
        bus.su_u_min !== 16'd5 || bus.su_u_max !== 16'd6) begin
      errors++;
      $display("FAIL nominal_bounds got %0d %0d %0d %0d exp 10 12 5 6",
               bus.su_x_min, bus.su_x_max, bus.su_u_min, bus.su_u_max);
    end
`ifdef SLACK_SCHED_RESID_EN
    checks++;
    if (bus.max_resid !== 16'd11) begin
      errors++;
      $display("FAIL resid_nominal got %0d exp 11", bus.max_resid);
    end
`else
    checks++;
    if (bus.max_resid !== '0) begin
      errors++;
      $display("FAIL resid_tied got %0d exp 0", bus.max_resid);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_idle busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_clamp;
    int cyc;
    set_cfg(10, 12, 5, 6);
    fill(0, 3, 10, 10, 1'b0);
    for (int k = 0; k < H; k++) push_exp(k);
    fork
      do_sweep(cyc);
      begin
        repeat (6) @(negedge clk);
        bus.cfg_x_min = 16'd0;
        bus.cfg_u_max = 16'd100;
      end
    join
    checks++;
    if (cyc != 29 || q.size() != 0) begin
      errors++;
      $display("FAIL clamp_sweep cyc=%0d pend=%0d exp 29 0", cyc, q.size());
    end
    checks++;
    if (bus.su_x_min !== 16'd10 || bus.su_u_max !== 16'd6) begin
      errors++;
      $display("FAIL cfg_midsweep got %0d %0d exp 10 6", bus.su_x_min, bus.su_u_max);
    end
`ifdef SLACK_SCHED_RESID_EN
    checks++;
    if (bus.max_resid !== 16'd10) begin
      errors++;
      $display("FAIL resid_clamp got %0d exp 10", bus.max_resid);
    end
`endif
    set_cfg(10, 12, 5, 6);
  endtask

  task automatic test_abort;
    int  cyc;
    bit  hit = 0;
    int  ndone = 0;
    set_cfg(10, 12, 5, 6);
    fill(0, 0, 0, 0, 1'b1);
    push_exp(0);
    push_exp(1);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.su_start && bus.rd_addr == AW'(2)) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_fire_k2 got timeout exp su_start");
    end
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy got %b exp 0", bus.busy);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone != 0 || q.size() != 0) begin
      errors++;
      $display("FAIL abort_nodone done=%0d pend=%0d exp 0 0", ndone, q.size());
    end
    checks++;
    if (bus.su_x_min !== 16'd10) begin
      errors++;
      $display("FAIL abort_bounds_held got %0d exp 10", bus.su_x_min);
    end
`ifdef SLACK_SCHED_RESID_EN
    checks++;
    if (bus.max_resid !== 16'd11) begin
      errors++;
      $display("FAIL abort_resid_held got %0d exp 11", bus.max_resid);
    end
`endif
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle busy got %b exp 0", bus.busy);
    end
    for (int k = 0; k < H; k++) push_exp(k);
    do_sweep(cyc);
    checks++;
    if (cyc != 29 || q.size() != 0) begin
      errors++;
      $display("FAIL abort_resweep cyc=%0d pend=%0d exp 29 0", cyc, q.size());
    end
  endtask

  task automatic test_ignored;
    int cyc;
    bit did_s = 0;
    bit did_d = 0;
    set_cfg(10, 12, 5, 6);
    fill(0, 0, 0, 0, 1'b1);
    for (int k = 0; k < H; k++) push_exp(k);
    fork
      do_sweep(cyc);
      begin
        for (int c = 0; c < 100 && !(did_s && did_d); c++) begin
          @(negedge clk);
          if (!did_d && bus.su_start) begin
            inj = 1'b1;
            did_d = 1;
            @(negedge clk);
            inj = 1'b0;
          end else if (!did_s && bus.rd_en && bus.rd_addr == AW'(1)) begin
            bus.start = 1'b1;
            did_s = 1;
            @(negedge clk);
            bus.start = 1'b0;
          end
        end
      end
    join
    checks++;
    if (!(did_s && did_d)) begin
      errors++;
      $display("FAIL ignored_stimulus got %b%b exp 11", did_s, did_d);
    end
    checks++;
    if (cyc != 29 || q.size() != 0) begin
      errors++;
      $display("FAIL ignored_timing cyc=%0d pend=%0d exp 29 0", cyc, q.size());
    end
  endtask

`ifdef SLACK_SCHED_RESID_EN
  task automatic test_resid_sat;
    int cyc;
    set_cfg(32767, 32767, 5, 6);
    fill(-32768, 0, 1, 4, 1'b0);
    for (int k = 0; k < H; k++) push_exp(k);
    do_sweep(cyc);
    checks++;
    if (bus.max_resid !== 16'd32767 || cyc != 29) begin
      errors++;
      $display("FAIL resid_sat got %0d cyc=%0d exp 32767 29", bus.max_resid, cyc);
    end
    set_cfg(10, 12, 5, 6);
  endtask
`endif

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.rd_x  = '0;
    bus.rd_y  = '0;
    bus.rd_u  = '0;
    bus.rd_g  = '0;
    bus.su_v  = '0;
    bus.su_z  = '0;
    set_cfg(10, 12, 5, 6);
    test_reset;
    test_reset_mid;
    test_nominal;
    test_clamp;
    test_abort;
    test_ignored;
`ifdef SLACK_SCHED_RESID_EN
    test_resid_sat;
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
